// File: rtl/mouse_packet_master.sv
// PS/2 mouse host controller: resets and configures the device (optionally
// negotiating IntelliMouse wheel mode), then assembles stream-mode packets.
module mouse_packet_master #(
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter bit          WHEEL_EN       = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic [7:0] MOUSE_DZ,
  output logic       SEND_INTERRUPT,
  output logic       WHEEL_MODE,
  output logic       INIT_FAIL
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned RW = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST = RW'(MAX_RETRIES - 1);

  localparam logic [2:0] S_START     = 3'd0;
  localparam logic [2:0] S_SEND      = 3'd1;
  localparam logic [2:0] S_WAIT_SENT = 3'd2;
  localparam logic [2:0] S_WAIT_RESP = 3'd3;
  localparam logic [2:0] S_STREAM    = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  localparam logic [3:0] CMD_ID   = 4'd7;
  localparam logic [3:0] CMD_LAST = 4'd8;

  logic [2:0]    state_q, state_d;
  logic [3:0]    cmd_idx_q, cmd_idx_d;
  logic [1:0]    resp_idx_q, resp_idx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [7:0]    pkt0_q, pkt0_d, pkt1_q, pkt1_d, pkt2_q, pkt2_d;
  logic [7:0]    status_q, status_d, dx_q, dx_d, dy_q, dy_d, dz_q, dz_d;
  logic          irq_q, irq_d;
  logic          wheel_q, wheel_d;
  logic          init_fail_q, init_fail_d;

  logic          reload, fail, timeout, id_slot;
  logic [3:0]    next_idx;
  logic [1:0]    pkt_last;

  // Init command script: reset, three sample-rate writes (200/100/80), get ID, enable.
  function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    cmd_byte = 8'hFF;
      4'd1:    cmd_byte = 8'hF3;
      4'd2:    cmd_byte = 8'hC8;
      4'd3:    cmd_byte = 8'hF3;
      4'd4:    cmd_byte = 8'h64;
      4'd5:    cmd_byte = 8'hF3;
      4'd6:    cmd_byte = 8'h50;
      4'd7:    cmd_byte = 8'hF2;
      default: cmd_byte = 8'hF4;
    endcase
  endfunction

  function automatic logic [7:0] exp_resp(input logic [3:0] idx, input logic [1:0] ridx);
    if (idx == 4'd0) begin
      case (ridx)
        2'd0:    exp_resp = 8'hFA;
        2'd1:    exp_resp = 8'hAA;
        default: exp_resp = 8'h00;
      endcase
    end else begin
      exp_resp = 8'hFA;
    end
  endfunction

  function automatic logic [1:0] last_resp(input logic [3:0] idx);
    if (idx == 4'd0)        last_resp = 2'd2;
    else if (idx == CMD_ID) last_resp = 2'd1;
    else                    last_resp = 2'd0;
  endfunction

  assign next_idx = (cmd_idx_q == 4'd0 && !WHEEL_EN) ? CMD_LAST : cmd_idx_q + 4'd1;
  assign pkt_last = wheel_q ? 2'd3 : 2'd2;
  assign timeout  = (timer_q == T_LAST);
  assign id_slot  = (cmd_idx_q == CMD_ID) && (resp_idx_q == 2'd1);

  always_comb begin
    state_d     = state_q;
    cmd_idx_d   = cmd_idx_q;
    resp_idx_d  = resp_idx_q;
    retry_d     = retry_q;
    tx_byte_d   = tx_byte_q;
    byte_idx_d  = byte_idx_q;
    pkt0_d      = pkt0_q;
    pkt1_d      = pkt1_q;
    pkt2_d      = pkt2_q;
    status_d    = status_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    dz_d        = dz_q;
    irq_d       = 1'b0;
    wheel_d     = wheel_q;
    init_fail_d = init_fail_q;
    reload      = 1'b0;
    fail        = 1'b0;

    case (state_q)
      S_START: begin
        state_d   = S_SEND;
        cmd_idx_d = 4'd0;
        tx_byte_d = cmd_byte(4'd0);
      end
      S_SEND: begin
        state_d = S_WAIT_SENT;
        reload  = 1'b1;
      end
      S_WAIT_SENT: begin
        if (BYTE_SENT) begin
          state_d    = S_WAIT_RESP;
          resp_idx_d = 2'd0;
          reload     = 1'b1;
        end else if (timeout) begin
          fail = 1'b1;
        end
      end
      S_WAIT_RESP: begin
        if (BYTE_READY) begin
          if (BYTE_ERROR_CODE != 2'b00) begin
            fail = 1'b1;
          end else if (!id_slot && BYTE_READ != exp_resp(cmd_idx_q, resp_idx_q)) begin
            fail = 1'b1;
          end else begin
            if (id_slot) wheel_d = (BYTE_READ == 8'h03);
            if (resp_idx_q == last_resp(cmd_idx_q)) begin
              if (cmd_idx_q == CMD_LAST) begin
                state_d    = S_STREAM;
                byte_idx_d = 2'd0;
              end else begin
                state_d   = S_SEND;
                cmd_idx_d = next_idx;
                tx_byte_d = cmd_byte(next_idx);
              end
            end else begin
              resp_idx_d = resp_idx_q + 2'd1;
              reload     = 1'b1;
            end
          end
        end else if (timeout) begin
          fail = 1'b1;
        end
      end
      S_STREAM: begin
        if (BYTE_READY) begin
          if (BYTE_ERROR_CODE != 2'b00) begin
            byte_idx_d = 2'd0;
          end else if (byte_idx_q != 2'd0 || BYTE_READ[3]) begin
            reload = 1'b1;
            case (byte_idx_q)
              2'd0:    pkt0_d = BYTE_READ;
              2'd1:    pkt1_d = BYTE_READ;
              default: pkt2_d = BYTE_READ;
            endcase
            if (byte_idx_q == pkt_last) begin
              // Final byte goes straight to the outputs, so all four update together.
              status_d   = pkt0_q;
              dx_d       = pkt1_q;
              dy_d       = wheel_q ? pkt2_q : BYTE_READ;
              dz_d       = wheel_q ? BYTE_READ : 8'h00;
              irq_d      = 1'b1;
              byte_idx_d = 2'd0;
            end else begin
              byte_idx_d = byte_idx_q + 2'd1;
            end
          end
        end else if (byte_idx_q != 2'd0 && timeout) begin
          byte_idx_d = 2'd0;
        end
      end
      default: ;
    endcase

    if (fail) begin
      retry_d = retry_q + 1'b1;
      wheel_d = 1'b0;
      if (retry_q >= R_LAST) begin
        state_d     = S_HALT;
        init_fail_d = 1'b1;
      end else begin
        state_d   = S_SEND;
        cmd_idx_d = 4'd0;
        tx_byte_d = cmd_byte(4'd0);
      end
    end

    if (reload)       timer_d = '0;
    else if (timeout) timer_d = timer_q;
    else              timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_START;
      cmd_idx_q   <= '0;
      resp_idx_q  <= '0;
      retry_q     <= '0;
      timer_q     <= '0;
      tx_byte_q   <= '0;
      byte_idx_q  <= '0;
      pkt0_q      <= '0;
      pkt1_q      <= '0;
      pkt2_q      <= '0;
      status_q    <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      dz_q        <= '0;
      irq_q       <= 1'b0;
      wheel_q     <= 1'b0;
      init_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_idx_q   <= cmd_idx_d;
      resp_idx_q  <= resp_idx_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      tx_byte_q   <= tx_byte_d;
      byte_idx_q  <= byte_idx_d;
      pkt0_q      <= pkt0_d;
      pkt1_q      <= pkt1_d;
      pkt2_q      <= pkt2_d;
      status_q    <= status_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      dz_q        <= dz_d;
      irq_q       <= irq_d;
      wheel_q     <= wheel_d;
      init_fail_q <= init_fail_d;
    end
  end

  assign SEND_BYTE      = (state_q == S_SEND);
  assign BYTE_TO_SEND   = tx_byte_q;
  assign READ_ENABLE    = (state_q == S_WAIT_RESP) || (state_q == S_STREAM);
  assign MOUSE_STATUS   = status_q;
  assign MOUSE_DX       = dx_q;
  assign MOUSE_DY       = dy_q;
  assign MOUSE_DZ       = dz_q;
  assign SEND_INTERRUPT = irq_q;
  assign WHEEL_MODE     = wheel_q;
  assign INIT_FAIL      = init_fail_q;

endmodule

// File: tb/tb_mouse_packet_master.sv
// Self-checking bench for mouse_packet_master: emulated device for init,
// table-driven packet vectors, and randomized stream checked by a packet model.
module tb_mouse_packet_master;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT = 1'b0;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ = 8'h00;
  logic [1:0] BYTE_ERROR_CODE = 2'b00;
  logic       BYTE_READY = 1'b0;
  logic [7:0] MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_DZ;
  logic       SEND_INTERRUPT, WHEEL_MODE, INIT_FAIL;

  mouse_packet_master #(
    .TIMEOUT_CYCLES(100),
    .MAX_RETRIES(3),
    .WHEEL_EN(1'b1)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND), .BYTE_SENT(BYTE_SENT),
    .READ_ENABLE(READ_ENABLE), .BYTE_READ(BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .BYTE_READY(BYTE_READY),
    .MOUSE_STATUS(MOUSE_STATUS), .MOUSE_DX(MOUSE_DX), .MOUSE_DY(MOUSE_DY),
    .MOUSE_DZ(MOUSE_DZ), .SEND_INTERRUPT(SEND_INTERRUPT),
    .WHEEL_MODE(WHEEL_MODE), .INIT_FAIL(INIT_FAIL)
  );

  always #5 CLK = ~CLK;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned irq_cnt = 0;

  always @(posedge CLK) begin
    #1;
    if (SEND_INTERRUPT === 1'b1) irq_cnt++;
  end

  // Packet model state
  logic [7:0]  mq[$];
  int unsigned plen = 4;
  logic [7:0]  m_st = 8'h00, m_dx = 8'h00, m_dy = 8'h00, m_dz = 8'h00;
  int unsigned m_irq = 0;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  err;
    int unsigned irqs;
    logic [7:0]  st, dx, dy, dz;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic [1:0] e);
    @(negedge CLK);
    BYTE_READ = d; BYTE_ERROR_CODE = e; BYTE_READY = 1'b1;
    @(negedge CLK);
    BYTE_READY = 1'b0; BYTE_ERROR_CODE = 2'b00;
  endtask

  task automatic wait_send(input logic [7:0] exp, input string nm);
    int unsigned n = 0;
    while (SEND_BYTE !== 1'b1 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL %s: no SEND_BYTE within 300 cycles, expected cmd %0h", nm, exp);
    end else begin
      chk({nm, "_cmd"}, BYTE_TO_SEND, exp);
      @(negedge CLK);
      chk({nm, "_one_cycle"}, SEND_BYTE, 0);
    end
  endtask

  task automatic pulse_sent();
    tick(2);
    BYTE_SENT = 1'b1;
    @(negedge CLK);
    BYTE_SENT = 1'b0;
    tick(1);
  endtask

  task automatic dev_init(input logic [7:0] id);
    logic [7:0] cmds [9];
    cmds = '{8'hFF, 8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF2, 8'hF4};
    for (int k = 0; k < 9; k++) begin
      wait_send(cmds[k], $sformatf("init%0d", k));
      chk("tx_stable", BYTE_TO_SEND, cmds[k]);
      pulse_sent();
      send_rx(8'hFA, 2'b00);
      if (k == 0) begin
        send_rx(8'hAA, 2'b00);
        send_rx(8'h00, 2'b00);
      end else if (k == 7) begin
        send_rx(id, 2'b00);
      end
    end
  endtask

  task automatic model_byte(input logic [7:0] d, input logic [1:0] e);
    if (e != 2'b00) begin
      mq.delete();
    end else if (mq.size() != 0 || d[3]) begin
      mq.push_back(d);
      if (mq.size() == plen) begin
        m_st = mq[0]; m_dx = mq[1]; m_dy = mq[2];
        m_dz = (plen == 4) ? mq[3] : 8'h00;
        m_irq++;
        mq.delete();
      end
    end
  endtask

  task automatic check_model(input string nm);
    chk({nm, "_status"}, MOUSE_STATUS, m_st);
    chk({nm, "_dx"}, MOUSE_DX, m_dx);
    chk({nm, "_dy"}, MOUSE_DY, m_dy);
    chk({nm, "_dz"}, MOUSE_DZ, m_dz);
    chk({nm, "_irqs"}, irq_cnt, m_irq);
  endtask

  task automatic run_table(input vec_t tv[$], input string nm);
    int unsigned base = irq_cnt;
    foreach (tv[i]) begin
      send_rx(tv[i].data, tv[i].err);
      model_byte(tv[i].data, tv[i].err);
      tick(2);
      chk($sformatf("%s%0d_status", nm, i), MOUSE_STATUS, tv[i].st);
      chk($sformatf("%s%0d_dx", nm, i), MOUSE_DX, tv[i].dx);
      chk($sformatf("%s%0d_dy", nm, i), MOUSE_DY, tv[i].dy);
      chk($sformatf("%s%0d_dz", nm, i), MOUSE_DZ, tv[i].dz);
      chk($sformatf("%s%0d_irqs", nm, i), irq_cnt - base, tv[i].irqs);
    end
  endtask

  task automatic run_random(input int unsigned n, input string nm);
    logic [7:0] d;
    logic [1:0] e;
    for (int unsigned i = 0; i < n; i++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 0) d[3] = 1'b1;
      e = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      send_rx(d, e);
      model_byte(d, e);
      if ($urandom_range(0, 9) == 0) begin
        tick(150);
        mq.delete();
      end else begin
        tick($urandom_range(0, 6));
      end
      check_model(nm);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_st = 8'h00; m_dx = 8'h00; m_dy = 8'h00; m_dz = 8'h00;
    m_irq = irq_cnt;
  endtask

  vec_t tab_a[$];
  vec_t tab_b[$];

  initial begin
    int unsigned sends, idle, total;

    tab_a = '{
      '{8'h08, 2'b00, 0, 8'h00, 8'h00, 8'h00, 8'h00},
      '{8'h05, 2'b00, 0, 8'h00, 8'h00, 8'h00, 8'h00},
      '{8'hFB, 2'b00, 0, 8'h00, 8'h00, 8'h00, 8'h00},
      '{8'h01, 2'b00, 1, 8'h08, 8'h05, 8'hFB, 8'h01}
    };
    tab_b = '{
      '{8'h09, 2'b00, 0, 8'h00, 8'h00, 8'h00, 8'h00},
      '{8'h10, 2'b00, 0, 8'h00, 8'h00, 8'h00, 8'h00},
      '{8'h20, 2'b00, 1, 8'h09, 8'h10, 8'h20, 8'h00},
      '{8'h00, 2'b00, 1, 8'h09, 8'h10, 8'h20, 8'h00},
      '{8'h08, 2'b00, 1, 8'h09, 8'h10, 8'h20, 8'h00},
      '{8'h01, 2'b00, 1, 8'h09, 8'h10, 8'h20, 8'h00},
      '{8'h02, 2'b00, 2, 8'h08, 8'h01, 8'h02, 8'h00},
      '{8'h0C, 2'b00, 2, 8'h08, 8'h01, 8'h02, 8'h00},
      '{8'h33, 2'b01, 2, 8'h08, 8'h01, 8'h02, 8'h00},
      '{8'h18, 2'b00, 2, 8'h08, 8'h01, 8'h02, 8'h00},
      '{8'h7F, 2'b00, 2, 8'h08, 8'h01, 8'h02, 8'h00},
      '{8'h80, 2'b00, 3, 8'h18, 8'h7F, 8'h80, 8'h00}
    };

    // Reset state
    tick(3);
    chk("rst_send", SEND_BYTE, 0);
    chk("rst_rden", READ_ENABLE, 0);
    chk("rst_status", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_DZ}, 0);
    chk("rst_flags", {SEND_INTERRUPT, WHEEL_MODE, INIT_FAIL}, 0);
    RESET = 1'b0;

    // Wheel device, 4-byte packets
    dev_init(8'h03);
    chk("wheel_mode", WHEEL_MODE, 1);
    chk("stream_rden", READ_ENABLE, 1);
    chk("no_fail_a", INIT_FAIL, 0);
    plen = 4;
    model_reset();
    run_table(tab_a, "tabA");
    run_random(150, "rndA");

    // Reset mid-packet
    send_rx(8'h08, 2'b00);
    send_rx(8'h05, 2'b00);
    RESET = 1'b1;
    @(negedge CLK);
    chk("midrst_outs", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_DZ}, 0);
    chk("midrst_flags", {SEND_BYTE, READ_ENABLE, SEND_INTERRUPT, WHEEL_MODE, INIT_FAIL}, 0);
    RESET = 1'b0;

    // One bad reply forces a retry from 0xFF, then plain 3-byte device
    wait_send(8'hFF, "after_rst");
    pulse_sent();
    send_rx(8'hFE, 2'b00);
    dev_init(8'h00);
    chk("no_wheel", WHEEL_MODE, 0);
    chk("no_fail_b", INIT_FAIL, 0);
    plen = 3;
    model_reset();
    run_table(tab_b, "tabB");
    run_random(150, "rndB");

    // Silent device: retries exhausted
    RESET = 1'b1;
    tick(2);
    RESET = 1'b0;
    sends = 0; idle = 0; total = 0;
    while (idle < 400 && total < 3000) begin
      @(negedge CLK);
      total++;
      if (SEND_BYTE === 1'b1) begin
        sends++;
        idle = 0;
        chk("silent_cmd", BYTE_TO_SEND, 8'hFF);
        pulse_sent();
        total += 4;
      end else begin
        idle++;
      end
    end
    chk("silent_sends", sends, 3);
    chk("silent_init_fail", INIT_FAIL, 1);
    chk("silent_rden", READ_ENABLE, 0);
    send_rx(8'h08, 2'b00);
    tick(3);
    chk("halt_ignores_rx", {SEND_BYTE, MOUSE_STATUS, SEND_INTERRUPT}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
